// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: ARM MEM stage running wait-stated async SRAM accesses and owning the MEM/WB register.
// Optional feature: define WRITE_POST_EN to let stores complete in the background without freezing the pipeline.
module mem_stage_sram_ctrl #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 5,
  parameter int SRAM_AW     = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_en_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [31:0]        alu_result_in,
  input  logic [31:0]        val_rm_in,
  input  logic [3:0]         dest_in,
  output logic               freeze,
  output logic               wb_en,
  output logic               mem_read,
  output logic [31:0]        alu_result,
  output logic [31:0]        mem_data,
  output logic [3:0]         dest,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);
`ifdef WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic is_wr, req, post_st, posted;
  logic [31:0] rdata_q;
  assign req = mem_read_in | mem_write_in;
  assign post_st = POST & mem_write_in & ~mem_read_in;
  assign posted = POST & is_wr;
  // A posted store only stalls later memory ops; reset forces freeze low immediately.
  always_comb begin
    state_nx = state == IDLE ? (req ? ACCESS : IDLE)
             : state == ACCESS ? (cnt != 4'd0 ? ACCESS : posted ? IDLE : DONE)
             : IDLE;
    freeze = ~rst & (state == IDLE ? req & ~post_st : state == ACCESS ? (posted ? req : 1'b1) : 1'b0);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_wr      <= 1'b0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        cnt        <= 4'(WAIT_CYCLES - 1);
        is_wr      <= ~mem_read_in;
        sram_addr  <= SRAM_AW'((alu_result_in - 32'(ADDR_BASE)) >> 2);
        sram_wdata <= val_rm_in;
        sram_oe_n  <= ~mem_read_in;
        sram_we_n  <= mem_read_in;
      end else if (state == ACCESS) begin
        cnt <= cnt != 4'd0 ? cnt - 4'd1 : cnt;
        if (cnt == 4'd0) begin
          rdata_q   <= is_wr ? rdata_q : sram_rdata;
          sram_we_n <= 1'b1;
          sram_oe_n <= 1'b1;
        end
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_en      <= 1'b0;
      mem_read   <= 1'b0;
      alu_result <= '0;
      mem_data   <= '0;
      dest       <= '0;
    end else if (freeze) begin
      wb_en    <= 1'b0;
      mem_read <= 1'b0;
    end else begin
      wb_en      <= wb_en_in;
      mem_read   <= mem_read_in;
      alu_result <= alu_result_in;
      dest       <= dest_in;
      mem_data   <= state == DONE ? rdata_q : mem_data;
    end
endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: drives the MEM stage as EX/MEM would (holding ops while frozen) against an async SRAM model.
module tb_mem_stage_sram_ctrl;
  localparam int W = 5;
`ifdef WRITE_POST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif
  typedef struct {
    logic        wb, rd, wr;
    logic [31:0] alu, val;
    logic [3:0]  d;
    bit          tab;
    int          exp_fz;
    logic [31:0] exp_md;
  } vec_t;

  logic clk = 0, rst = 1;
  logic wb_en_in = 0, mem_read_in = 0, mem_write_in = 0;
  logic [31:0] alu_result_in = 0, val_rm_in = 0;
  logic [3:0] dest_in = 0;
  logic freeze, wb_en, mem_read, sram_we_n, sram_oe_n;
  logic [31:0] alu_result, mem_data, sram_wdata, sram_rdata;
  logic [3:0] dest;
  logic [16:0] sram_addr;

  int checks = 0, errors = 0, cyc = 0, free_at = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] sram [256];
  bit written [256];
  logic pre_en = 0;
  logic [7:0] pre_addr = 0;
  logic [31:0] pre_data = 0;

  mem_stage_sram_ctrl dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .alu_result_in(alu_result_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .freeze(freeze), .wb_en(wb_en), .mem_read(mem_read),
    .alu_result(alu_result), .mem_data(mem_data), .dest(dest), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] seed_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Asynchronous SRAM: unwritten words read back a fixed per-address pattern.
  assign sram_rdata = sram_oe_n ? 32'h0 :
                      written[sram_addr[7:0]] ? sram[sram_addr[7:0]] : seed_word(int'(sram_addr[7:0]));
  always @(negedge clk)
    if (!sram_we_n) begin
      sram[sram_addr[7:0]] <= sram_wdata;
      written[sram_addr[7:0]] <= 1'b1;
    end else if (pre_en) begin
      sram[pre_addr] <= pre_data;
      written[pre_addr] <= 1'b1;
    end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  // Strobe monitor: every completed strobe lasts W cycles with address/data held.
  int we_len = 0, oe_len = 0, we_bad = 0, oe_bad = 0;
  logic [16:0] we_a, oe_a;
  logic [31:0] we_d;
  always @(negedge clk) begin
    if (rst) begin
      we_len = 0; oe_len = 0; we_bad = 0; oe_bad = 0;
    end else begin
      if (!sram_we_n) begin
        if (we_len == 0) begin we_a = sram_addr; we_d = sram_wdata; end
        else if (sram_addr !== we_a || sram_wdata !== we_d) we_bad++;
        we_len++;
      end else if (we_len != 0) begin
        chk("we_n_low_cycles", we_len, W);
        chk("we_addr_data_stable", we_bad, 0);
        we_len = 0; we_bad = 0;
      end
      if (!sram_oe_n) begin
        if (oe_len == 0) oe_a = sram_addr;
        else if (sram_addr !== oe_a) oe_bad++;
        oe_len++;
      end else if (oe_len != 0) begin
        chk("oe_n_low_cycles", oe_len, W);
        chk("oe_addr_stable", oe_bad, 0);
        oe_len = 0; oe_bad = 0;
      end
    end
  end

  // Reference: each op issued at cycle s waits for the SRAM to be free, then blocks W+1
  // cycles (loads, blocking stores) or none (posted stores, which keep the SRAM busy W+1 cycles).
  function automatic void predict(input logic rd, input logic wr, input logic [31:0] alu,
                                  input logic [31:0] val, output int efz, output logic [31:0] emd);
    int s, start;
    logic [7:0] w;
    bit post;
    s = cyc;
    start = free_at > s ? free_at : s;
    w = 8'((alu - 32'd1024) >> 2);
    post = POST && wr && !rd;
    efz = 0;
    emd = ref_mem[w];
    if (rd || wr) begin
      efz = start - s + (post ? 0 : W + 1);
      free_at = start + W + (post ? 1 : 2);
      if (!rd) ref_mem[w] = val;
    end
  endfunction

  task automatic run_op(input vec_t v);
    int efz, fz;
    logic [31:0] emd;
    logic [7:0] w;
    bit f;
    fz = 0;
    w = 8'((v.alu - 32'd1024) >> 2);
    predict(v.rd, v.wr, v.alu, v.val, efz, emd);
    if (!v.tab) begin v.exp_fz = efz; v.exp_md = emd; end
    wb_en_in = v.wb; mem_read_in = v.rd; mem_write_in = v.wr;
    alu_result_in = v.alu; val_rm_in = v.val; dest_in = v.d;
    do begin
      @(negedge clk);
      f = freeze;
      fz += int'(f);
      @(posedge clk);
      #1;
    end while (f && fz < 64);
    chk("freeze_cycles", fz, v.exp_fz);
    chk("wb_en", {31'b0, wb_en}, {31'b0, v.wb});
    chk("mem_read", {31'b0, mem_read}, {31'b0, v.rd});
    chk("alu_result", alu_result, v.alu);
    chk("dest", {28'b0, dest}, {28'b0, v.d});
    if (v.rd) chk("mem_data", mem_data, v.exp_md);
    if (v.rd || v.wr) chk("sram_addr", 32'(sram_addr), 32'(w));
    if (v.wr && !v.rd) chk("sram_wdata", sram_wdata, v.val);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wb_en"}, {31'b0, wb_en}, 0);
    chk({tag, "_mem_read"}, {31'b0, mem_read}, 0);
    chk({tag, "_alu_result"}, alu_result, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
    chk({tag, "_dest"}, {28'b0, dest}, 0);
    chk({tag, "_we_n"}, {31'b0, sram_we_n}, 1);
    chk({tag, "_oe_n"}, {31'b0, sram_oe_n}, 1);
    chk({tag, "_freeze"}, {31'b0, freeze}, 0);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    ref_mem[1] = 32'hDEADBEEF;
    pre_en = 1; pre_addr = 8'd1; pre_data = 32'hDEADBEEF;
    #12;
    chk_reset_state("por");
    chk("por_sram_addr", 32'(sram_addr), 0);
    chk("por_sram_wdata", sram_wdata, 0);
    pre_en = 0;
    @(negedge clk); #1 rst = 0;
    @(posedge clk); #1;
    free_at = 0;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h55,       32'h0,         4'd3, 1'b1, 0,                32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'd1028,     32'h0,         4'd5, 1'b1, 6,                32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'd1032,     32'h12345678,  4'd7, 1'b1, POST ? 0 : 6,     32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'd1032,     32'h0,         4'd8, 1'b1, POST ? 11 : 6,    32'h12345678};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'd1036,     32'hCAFEF00D,  4'd2, 1'b1, POST ? 0 : 6,     32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h77,       32'h0,         4'd4, 1'b1, 0,                32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'd1036,     32'h0,         4'd6, 1'b1, POST ? 10 : 6,    32'hCAFEF00D};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'd1028,     32'hBAD0BAD0,  4'd1, 1'b1, 6,                32'hDEADBEEF};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'd1028,     32'h0,         4'd9, 1'b1, 6,                32'hDEADBEEF};
    for (int i = 0; i < 9; i++) run_op(tbl[i]);
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 6);
      v.wb = 1'($urandom);
      v.rd = (k == 2 || k == 3 || k == 6);
      v.wr = (k == 4 || k == 5 || k == 6);
      v.alu = (v.rd || v.wr) ? 32'd1024 + $urandom_range(0, 255) : $urandom;
      v.val = $urandom;
      v.d = 4'($urandom);
      v.tab = 1'b0; v.exp_fz = 0; v.exp_md = 0;
      run_op(v);
    end
    // Reset pulse in the middle of a load
    run_op('{1'b1, 1'b0, 1'b0, 32'hA5A5, 32'h0, 4'd9, 1'b0, 0, 32'h0});
    wb_en_in = 1; mem_read_in = 1; mem_write_in = 0; alu_result_in = 32'd1032; dest_in = 4'd4;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 chk_reset_state("midrst");
    @(negedge clk); #1 rst = 0;
    wb_en_in = 0; mem_read_in = 0;
    free_at = 0;
    @(posedge clk); #1;
    // Reset in the third ACCESS cycle of a store
    wb_en_in = 0; mem_read_in = 0; mem_write_in = 1; alu_result_in = 32'd1024 + 32'd1000; val_rm_in = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_we_n", {31'b0, sram_we_n}, 1);
    chk("abort_oe_n", {31'b0, sram_oe_n}, 1);
    chk("abort_freeze", {31'b0, freeze}, 0);
    mem_write_in = 0;
    @(negedge clk); #1 rst = 0;
    free_at = 0;
    @(posedge clk); #1;
    run_op('{1'b1, 1'b0, 1'b0, 32'h3C3C, 32'h0, 4'd11, 1'b0, 0, 32'h0});
    run_op('{1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd12, 1'b0, 0, 32'h0});
    wb_en_in = 0; mem_read_in = 0; mem_write_in = 0;
    repeat (10) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
